// File: rtl/tekbot_pkg.sv
// rtl/tekbot_pkg.sv - shared types and timing constants for the TekBot whisker front end
package tekbot_pkg;

  // Event-holding state of the hit latch
  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } evt_state_e;

  // Divided system clock that the whisker logic runs on
  localparam int unsigned CLK_HZ = 2_080_000;

  // A switch level must be stable this long before it is believed
  localparam int unsigned DEBOUNCE_MS = 10;

  // 2.08 MHz * 10 ms = 20800 samples
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/tekbot_whisker_rx_if.sv
// rtl/tekbot_whisker_rx_if.sv - whisker pins, ack and hit flags between switches and motion FSM
interface tekbot_whisker_rx_if;

  logic whisker_l_i;
  logic whisker_r_i;
  logic ack_i;
  logic DigitalLDir;
  logic DigitalRDir;
  logic hit_valid_o;
  logic stable_l_o;
  logic stable_r_o;

  // Whisker receiver side
  modport slave (
    input  whisker_l_i, whisker_r_i, ack_i,
    output DigitalLDir, DigitalRDir, hit_valid_o, stable_l_o, stable_r_o
  );

  // Board pins plus motion FSM side
  modport master (
    output whisker_l_i, whisker_r_i, ack_i,
    input  DigitalLDir, DigitalRDir, hit_valid_o, stable_l_o, stable_r_o
  );

endinterface

// File: rtl/whisker_debounce.sv
// rtl/whisker_debounce.sv - one whisker channel: sync, polarity, debounce counter, press pulse
module whisker_debounce
  import tekbot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 15,
  parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic raw_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ;

  // Next state: count disagreeing samples, flip the stable level on the last one
  always_comb begin
    sync1_d  = raw_i ^ RAW_ACTIVE_LOW;
    sync2_d  = sync1_q;
    differ   = (sync2_q != stable_q);
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (differ) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        // Only a 0->1 move of the stable level is a press; releases are silent
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Channel state registers, all cleared to "not pressed" on reset
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/tekbot_whisker_rx.sv
// rtl/tekbot_whisker_rx.sv - whisker front end; WHISKER_HOLD_EN enables sticky hit flags with ack
module tekbot_whisker_rx
  import tekbot_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 15,
  parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
  input logic                 clk_i,
  input logic                 reset_n,
  tekbot_whisker_rx_if.slave  bus
);

  logic stable_l, stable_r;
  logic press_l, press_r;
  logic dir_l_q, dir_l_d;
  logic dir_r_q, dir_r_d;
  logic hit_q, hit_d;

  whisker_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
  ) u_deb_l (
    .clk_i    (clk_i),
    .reset_n  (reset_n),
    .raw_i    (bus.whisker_l_i),
    .stable_o (stable_l),
    .press_o  (press_l)
  );

  whisker_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
  ) u_deb_r (
    .clk_i    (clk_i),
    .reset_n  (reset_n),
    .raw_i    (bus.whisker_r_i),
    .stable_o (stable_r),
    .press_o  (press_r)
  );

`ifdef WHISKER_HOLD_EN
  evt_state_e state_q, state_d;

  // Hit latch: presses OR in while held; an ack keeps only a press arriving with it
  always_comb begin
    state_d = state_q;
    dir_l_d = dir_l_q;
    dir_r_d = dir_r_q;
    case (state_q)
      IDLE: begin
        if (press_l || press_r) begin
          dir_l_d = press_l;
          dir_r_d = press_r;
          state_d = HELD;
        end
      end
      HELD: begin
        if (bus.ack_i) begin
          dir_l_d = press_l;
          dir_r_d = press_r;
          state_d = (press_l || press_r) ? HELD : IDLE;
        end else begin
          dir_l_d = dir_l_q | press_l;
          dir_r_d = dir_r_q | press_r;
        end
      end
      default: begin
        dir_l_d = 1'b0;
        dir_r_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    hit_d = dir_l_d | dir_r_d;
  end

  // Event state register
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
`else
  logic unused_hold_inputs;
  assign unused_hold_inputs = ^{press_l, press_r, bus.ack_i};

  // Flags simply follow the debounced levels, one register later
  always_comb begin
    dir_l_d = stable_l;
    dir_r_d = stable_r;
    hit_d   = stable_l | stable_r;
  end
`endif

  // Registered flag outputs
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      dir_l_q <= 1'b0;
      dir_r_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      dir_l_q <= dir_l_d;
      dir_r_q <= dir_r_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.DigitalLDir = dir_l_q;
  assign bus.DigitalRDir = dir_r_q;
  assign bus.hit_valid_o = hit_q;
  assign bus.stable_l_o  = stable_l;
  assign bus.stable_r_o  = stable_r;

endmodule

// File: doc/tekbot_whisker_rx.md
# tekbot_whisker_rx

- Input front end for the TekBot motion state machine.
- Function:
  - Synchronizes and debounces the left and right whisker (bumper) switches.
  - Turns each debounced press into a sticky hit flag.
  - Holds the flag on DigitalLDir / DigitalRDir until the state machine acknowledges it.
- Sits between the board switch pins and the FSM.
- Runs on the divided system clock so that no press is lost between FSM steps.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 20800: consecutive stable samples required to accept a level change (10 ms at 2.08 MHz); legal range 2..32767.
- CNT_W, 15: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- RAW_ACTIVE_LOW, 1: 1 = switch pulls pin low when pressed.

Ports:
- clk_i, in, 1: single clock, rising edge.
- reset_n, in, 1: reset; one clock; asynchronous assert, active-low.
- whisker_l_i, in, 1: raw left switch, asynchronous to clk_i.
- whisker_r_i, in, 1: raw right switch, asynchronous to clk_i.
- ack_i, in, 1: FSM has consumed the current hit; level-sampled.
- DigitalLDir, out, 1: left hit flag, registered.
- DigitalRDir, out, 1: right hit flag, registered.
- hit_valid_o, out, 1: DigitalLDir | DigitalRDir, registered.
- stable_l_o, out, 1: debounced left level, 1 = pressed.
- stable_r_o, out, 1: debounced right level, 1 = pressed.

## Operation
- **Polarity:** raw input is XORed with RAW_ACTIVE_LOW, so 1 = pressed internally.
- **Synchronizer:** two flops per channel; reset value 0 (not pressed).
- **Debounce, per channel:**
  - Counter increments while the synchronized level differs from the stable level.
  - Counter clears to 0 on any cycle where they match.
  - When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ:
    - the stable level toggles;
    - the counter clears.
  - Counter never wraps.
- **Press pulse:** one-cycle pulse on a 0->1 transition of the stable level. Releases generate no event.
- **Event FSM** (states IDLE, HELD; reset state IDLE):
  - IDLE:
    - Any press pulse sets the corresponding flag(s) and moves to HELD.
    - Both pulses in the same cycle set both flags.
  - HELD, further press pulses: OR into the flags (a hit on the other side is not lost).
  - HELD, ack_i=1 with no press pulse: clears both flags and returns to IDLE.
  - HELD, ack_i=1 together with a press pulse:
    - old flags are cleared;
    - only the new pulse's flag is set;
    - state stays HELD.
  - ack_i in IDLE is ignored.
- **Reset:** the following are all 0 and take effect immediately on reset_n low, including mid-debounce or while HELD:
  - all outputs;
  - all counters;
  - the synchronizer flops.
- **After reset release:** a switch already held pressed produces one press event after full debounce.

## Timing
- Raw change first sampled at edge 0:
  - synchronized value visible after edge 1;
  - stable_x_o changes at edge DEBOUNCE_CYCLES+1;
  - DigitalxDir / hit_valid_o set at edge DEBOUNCE_CYCLES+2.
- A raw glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) produces no output change.
- Ack latency: ack_i high at edge n clears flags at edge n. Flags are low in the cycle after the edge where ack_i was sampled high.
- Ack handshake:
  - The FSM must hold ack_i for exactly one cycle per consumed hit.
  - A held ack_i clears every subsequent press one cycle after it appears. This is legal, but the press is still visible for one cycle.

## Configuration
- Macro: WHISKER_HOLD_EN.
- Defined: event FSM and ack handshake as above.
- Undefined:
  - Event FSM is removed; ack_i is unused.
  - DigitalLDir = stable_l_o and DigitalRDir = stable_r_o, registered with one extra cycle.
  - hit_valid_o = OR of those two outputs.
  - Flags follow the debounced switch levels directly.

## Structure
- Package tekbot_pkg holds:
  - the event-state enum {IDLE, HELD};
  - the 2.08 MHz clock constant;
  - the default DEBOUNCE_CYCLES derivation (10 ms).
- Sub-module whisker_debounce (one channel) contains:
  - synchronizer;
  - polarity inversion;
  - counter;
  - stable register;
  - press pulse.
- whisker_debounce is instantiated twice.
- Event FSM and output registers live in tekbot_whisker_rx.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, RAW_ACTIVE_LOW=1.
- **Reset values:** reset_n low with whisker_l_i=0 (pressed) → all outputs 0. After release, DigitalLDir=1 exactly 6 edges later.
- **Clean press:**
  - whisker_l_i 1->0 and held → stable_l_o=1 at edge 5, DigitalLDir=1 and hit_valid_o=1 at edge 6.
  - Release, then ack_i one cycle → flags 0.
- **Glitch rejection:** whisker_r_i low for 3 cycles then high → DigitalRDir, stable_r_o stay 0 throughout.
- **Flag OR-ing:**
  - Left press, no ack; right press 20 cycles later → DigitalLDir=1 and DigitalRDir=1.
  - Single ack → both flags 0.
- **Ack/press collision:** HELD with left flag set; ack_i coincides with a right press pulse → next cycle DigitalLDir=0, DigitalRDir=1, hit_valid_o=1.
- **Mid-debounce reset:**
  - reset_n pulsed low while counter=2 → counter 0.
  - After release, full 4-cycle debounce is required again before stable_x_o=1.
